// File: rtl/set_region_pkg.sv
// Shared encodings for the lattice-set counter.
// Mode constants select the set expression; state_t is the scan FSM.
package set_region_pkg;

   localparam logic [1:0] MODE_A            = 2'b00;
   localparam logic [1:0] MODE_AND          = 2'b01;
   localparam logic [1:0] MODE_XOR          = 2'b10;
   localparam logic [1:0] MODE_TWO_OF_THREE = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/set_point_member.sv
// Combinational point-in-circle test: (px-cx)^2 + (py-cy)^2 <= r^2.
// Widths grow so that no term is ever truncated.
module set_point_member #(
   parameter int COORD_W = 4
) (
   input  logic [COORD_W-1:0] i_px,
   input  logic [COORD_W-1:0] i_py,
   input  logic [COORD_W-1:0] i_cx,
   input  logic [COORD_W-1:0] i_cy,
   input  logic [COORD_W-1:0] i_r,
   output logic               o_hit
);

   logic [COORD_W-1:0]   w_dx;
   logic [COORD_W-1:0]   w_dy;
   logic [2*COORD_W-1:0] w_dx2;
   logic [2*COORD_W-1:0] w_dy2;
   logic [2*COORD_W-1:0] w_r2;
   logic [2*COORD_W:0]   w_sum;

   assign w_dx  = (i_px >= i_cx) ? (i_px - i_cx) : (i_cx - i_px);
   assign w_dy  = (i_py >= i_cy) ? (i_py - i_cy) : (i_cy - i_py);
   assign w_dx2 = (2*COORD_W)'(w_dx) * (2*COORD_W)'(w_dx);
   assign w_dy2 = (2*COORD_W)'(w_dy) * (2*COORD_W)'(w_dy);
   assign w_r2  = (2*COORD_W)'(i_r) * (2*COORD_W)'(i_r);
   assign w_sum = (2*COORD_W+1)'(w_dx2) + (2*COORD_W+1)'(w_dy2);
   assign o_hit = (w_sum <= (2*COORD_W+1)'(w_r2));

endmodule

// File: rtl/set_region_counter.sv
// Scans every grid point once and counts hits of the selected
// set expression over up to three circles.
module set_region_counter
   import set_region_pkg::*;
#(
   parameter  int GRID_N  = 8,
   parameter  int COORD_W = 4,
   localparam int CNT_W   = $clog2(GRID_N*GRID_N+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [6*COORD_W-1:0]   central,
   input  logic [3*COORD_W-1:0]   radius,
   input  logic [1:0]             mode,
   output logic                   busy,
   output logic                   valid,
   output logic [CNT_W-1:0]       candidate
);

   localparam logic [COORD_W-1:0] LAST = COORD_W'(GRID_N);
   localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

   state_t               r_state;
   logic [6*COORD_W-1:0] r_cen;
   logic [3*COORD_W-1:0] r_rad;
   logic [1:0]           r_mode;
   logic [COORD_W-1:0]   r_px;
   logic [COORD_W-1:0]   r_py;
   logic [CNT_W-1:0]     r_cnt;

   logic w_ha;
   logic w_hb;
   logic w_hc;
   logic w_hit;

   set_point_member #(.COORD_W(COORD_W)) u_mem_a (
      .i_px  (r_px),
      .i_py  (r_py),
      .i_cx  (r_cen[6*COORD_W-1 -: COORD_W]),
      .i_cy  (r_cen[5*COORD_W-1 -: COORD_W]),
      .i_r   (r_rad[3*COORD_W-1 -: COORD_W]),
      .o_hit (w_ha)
   );

   set_point_member #(.COORD_W(COORD_W)) u_mem_b (
      .i_px  (r_px),
      .i_py  (r_py),
      .i_cx  (r_cen[4*COORD_W-1 -: COORD_W]),
      .i_cy  (r_cen[3*COORD_W-1 -: COORD_W]),
      .i_r   (r_rad[2*COORD_W-1 -: COORD_W]),
      .o_hit (w_hb)
   );

   set_point_member #(.COORD_W(COORD_W)) u_mem_c (
      .i_px  (r_px),
      .i_py  (r_py),
      .i_cx  (r_cen[2*COORD_W-1 -: COORD_W]),
      .i_cy  (r_cen[COORD_W-1 -: COORD_W]),
      .i_r   (r_rad[COORD_W-1 -: COORD_W]),
      .o_hit (w_hc)
   );

   always_comb begin
      w_hit = 1'b0;
      unique case (r_mode)
         MODE_A:            w_hit = w_ha;
         MODE_AND:          w_hit = w_ha & w_hb;
         MODE_XOR:          w_hit = w_ha ^ w_hb;
         MODE_TWO_OF_THREE: w_hit = (w_ha & w_hb & ~w_hc)
                                  | (w_ha & ~w_hb & w_hc)
                                  | (~w_ha & w_hb & w_hc);
         default:           w_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cen     <= '0;
         r_rad     <= '0;
         r_mode    <= MODE_A;
         r_px      <= ONE;
         r_py      <= ONE;
         r_cnt     <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         candidate <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (en) begin
                  r_cen   <= central;
                  r_rad   <= radius;
                  r_mode  <= mode;
                  r_cnt   <= '0;
                  r_px    <= ONE;
                  r_py    <= ONE;
                  busy    <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               r_cnt <= r_cnt + CNT_W'(w_hit);
               if (r_px == LAST) begin
                  r_px <= ONE;
                  // last point: fold its hit straight into the result
                  if (r_py == LAST) begin
                     candidate <= r_cnt + CNT_W'(w_hit);
                     valid     <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_py <= r_py + ONE;
                  end
               end else begin
                  r_px <= r_px + ONE;
               end
            end
            DONE: begin
               valid   <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_region_counter.sv
// Bench for set_region_counter: directed cases, random jobs
// against a point-by-point set model, isolation and reset abort.
module tb_set_region_counter;

   localparam int GRID_N  = 8;
   localparam int COORD_W = 4;
   localparam int CNT_W   = $clog2(GRID_N*GRID_N+1);
   localparam int LAT     = GRID_N*GRID_N;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 en = 1'b0;
   logic [6*COORD_W-1:0] central = '0;
   logic [3*COORD_W-1:0] radius = '0;
   logic [1:0]           mode = 2'b00;
   logic                 busy;
   logic                 valid;
   logic [CNT_W-1:0]     candidate;

   int n_pass = 0;
   int n_total = 0;

   set_region_counter #(.GRID_N(GRID_N), .COORD_W(COORD_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .central   (central),
      .radius    (radius),
      .mode      (mode),
      .busy      (busy),
      .valid     (valid),
      .candidate (candidate)
   );

   always #5 clk = ~clk;

   function automatic bit inside_c(int x, int y, int cx, int cy, int r);
      return ((x-cx)*(x-cx) + (y-cy)*(y-cy)) <= r*r;
   endfunction

   function automatic int model(logic [6*COORD_W-1:0] cen,
                                logic [3*COORD_W-1:0] rad,
                                logic [1:0] md);
      int c [6];
      int r [3];
      int n;
      int k;
      bit a, b, cc;
      for (int i = 0; i < 6; i++)
         c[i] = int'(cen[(5-i)*COORD_W +: COORD_W]);
      for (int i = 0; i < 3; i++)
         r[i] = int'(rad[(2-i)*COORD_W +: COORD_W]);
      n = 0;
      for (int y = 1; y <= GRID_N; y++)
         for (int x = 1; x <= GRID_N; x++) begin
            a  = inside_c(x, y, c[0], c[1], r[0]);
            b  = inside_c(x, y, c[2], c[3], r[1]);
            cc = inside_c(x, y, c[4], c[5], r[2]);
            k = int'(a) + int'(b) + int'(cc);
            case (md)
               2'b00: n += int'(a);
               2'b01: n += int'(a && b);
               2'b10: n += int'(a != b);
               default: n += int'(k == 2);
            endcase
         end
      return n;
   endfunction

   function automatic logic [6*COORD_W-1:0] pk_c(int xa, int ya, int xb,
                                                 int yb, int xc, int yc);
      return {COORD_W'(xa), COORD_W'(ya), COORD_W'(xb),
              COORD_W'(yb), COORD_W'(xc), COORD_W'(yc)};
   endfunction

   function automatic logic [3*COORD_W-1:0] pk_r(int ra, int rb, int rc);
      return {COORD_W'(ra), COORD_W'(rb), COORD_W'(rc)};
   endfunction

   // Runs one job; lat = edges from E0 to valid (-1 on timeout).
   task automatic run_job(input logic [6*COORD_W-1:0] cen,
                          input logic [3*COORD_W-1:0] rad,
                          input logic [1:0] md,
                          output int lat,
                          output logic [CNT_W-1:0] cand,
                          output logic busy_after,
                          output bit busy_held);
      @(negedge clk);
      central = cen;
      radius  = rad;
      mode    = md;
      en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      lat = -1;
      cand = '0;
      busy_after = 1'b1;
      busy_held = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b1) busy_held = 1'b0;
         if (valid === 1'b1) begin
            lat = k;
            cand = candidate;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk);
         #1;
         busy_after = busy;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_total++;
      if ({busy, valid, candidate} !== '0) begin
         $display("FAIL reset_outputs: got busy=%b valid=%b cand=%0d want 0/0/0",
                  busy, valid, candidate);
      end else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         $display("FAIL reset_idle: got busy=%b valid=%b want 0/0", busy, valid);
      end else n_pass++;
   endtask

   task automatic test_directed();
      int lat;
      logic [CNT_W-1:0] cand;
      logic ba;
      bit bh;
      logic [6*COORD_W-1:0] cens [6];
      logic [3*COORD_W-1:0] rads [6];
      logic [1:0] mds [6];
      int exp_c [6];
      cens[0] = pk_c(4,4,0,0,0,0); rads[0] = pk_r(2,0,0); mds[0] = 2'b00;
      exp_c[0] = 13;
      cens[1] = pk_c(3,3,5,3,0,0); rads[1] = pk_r(2,2,0); mds[1] = 2'b01;
      exp_c[1] = 5;
      cens[2] = pk_c(3,3,5,3,0,0); rads[2] = pk_r(2,2,0); mds[2] = 2'b10;
      exp_c[2] = 16;
      cens[3] = pk_c(1,1,0,0,0,0); rads[3] = pk_r(2,0,0); mds[3] = 2'b00;
      exp_c[3] = 6;
      cens[4] = pk_c(3,3,5,3,8,8); rads[4] = pk_r(2,2,0); mds[4] = 2'b11;
      exp_c[4] = 5;
      cens[5] = pk_c(8,8,0,0,0,0); rads[5] = pk_r(0,0,0); mds[5] = 2'b00;
      exp_c[5] = 1;
      for (int i = 0; i < 6; i++) begin
         run_job(cens[i], rads[i], mds[i], lat, cand, ba, bh);
         n_total++;
         if (cand !== CNT_W'(exp_c[i])) begin
            $display("FAIL directed_%0d_count: got %0d want %0d",
                     i, cand, exp_c[i]);
         end else n_pass++;
         n_total++;
         if (lat !== LAT) begin
            $display("FAIL directed_%0d_latency: got %0d want %0d",
                     i, lat, LAT);
         end else n_pass++;
         n_total++;
         if (ba !== 1'b0 || bh !== 1'b1) begin
            $display("FAIL directed_%0d_busy: got after=%b held=%0d want 0/1",
                     i, ba, bh);
         end else n_pass++;
      end
   endtask

   task automatic test_random();
      int lat;
      int exp_n;
      logic [CNT_W-1:0] cand;
      logic ba;
      bit bh;
      logic [6*COORD_W-1:0] cen;
      logic [3*COORD_W-1:0] rad;
      logic [1:0] md;
      for (int i = 0; i < 16; i++) begin
         cen = {$urandom, $urandom};
         rad = 3*COORD_W'($urandom_range(0, 4095));
         if (i % 2 == 0) rad = pk_r($urandom_range(0,5), $urandom_range(0,5),
                                    $urandom_range(0,5));
         md = 2'(i % 4);
         exp_n = model(cen, rad, md);
         run_job(cen, rad, md, lat, cand, ba, bh);
         n_total++;
         if (cand !== CNT_W'(exp_n) || lat !== LAT) begin
            $display("FAIL random_%0d: got cnt=%0d lat=%0d want cnt=%0d lat=%0d (c=%h r=%h m=%0d)",
                     i, cand, lat, exp_n, LAT, cen, rad, md);
         end else n_pass++;
      end
   endtask

   task automatic test_isolation();
      int lat;
      int busy_cycles;
      logic [CNT_W-1:0] cand;
      @(negedge clk);
      central = pk_c(4,4,0,0,0,0);
      radius  = pk_r(2,0,0);
      mode    = 2'b00;
      en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      lat = -1;
      cand = '0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (k == 20) begin
            @(negedge clk);
            central = pk_c(1,1,8,8,8,1);
            radius  = pk_r(15,15,15);
            mode    = 2'b11;
            en      = 1'b1;
            @(negedge clk);
            en = 1'b0;
            k = k + 1;
         end
         if (valid === 1'b1) begin
            lat = k;
            cand = candidate;
            break;
         end
      end
      n_total++;
      if (cand !== CNT_W'(13) || lat !== LAT) begin
         $display("FAIL isolation_result: got cnt=%0d lat=%0d want 13 %0d",
                  cand, lat, LAT);
      end else n_pass++;
      busy_cycles = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1 || valid === 1'b1) busy_cycles++;
      end
      n_total++;
      if (busy_cycles !== 0) begin
         $display("FAIL isolation_no_second_job: got %0d busy cycles want 0",
                  busy_cycles);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      int v [$];
      logic [CNT_W-1:0] c [$];
      @(negedge clk);
      central = pk_c(3,3,5,3,0,0);
      radius  = pk_r(2,2,0);
      mode    = 2'b10;
      en      = 1'b1;
      for (int t = 0; t < 400; t++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) begin
            v.push_back(t);
            c.push_back(candidate);
            if (v.size() == 2) break;
         end
      end
      @(negedge clk);
      en = 1'b0;
      n_total++;
      if (v.size() != 2) begin
         $display("FAIL b2b_pulses: got %0d valid pulses want 2", v.size());
      end else if (v[1] - v[0] != LAT + 2 || c[0] !== CNT_W'(16)
                   || c[1] !== CNT_W'(16)) begin
         $display("FAIL b2b_spacing: got gap=%0d cnt=%0d/%0d want gap=%0d cnt=16",
                  v[1] - v[0], c[0], c[1], LAT + 2);
      end else n_pass++;
      repeat (4) @(negedge clk);
      n_total++;
      if (busy !== 1'b0) begin
         $display("FAIL b2b_idle: got busy=%b want 0", busy);
      end else n_pass++;
   endtask

   task automatic test_reset_abort();
      int nvalid;
      int lat;
      logic [CNT_W-1:0] cand;
      logic ba;
      bit bh;
      @(negedge clk);
      central = pk_c(4,4,0,0,0,0);
      radius  = pk_r(3,0,0);
      mode    = 2'b00;
      en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if ({busy, valid, candidate} !== '0) begin
         $display("FAIL abort_outputs: got busy=%b valid=%b cand=%0d want 0/0/0",
                  busy, valid, candidate);
      end else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      nvalid = 0;
      for (int k = 0; k < 90; k++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1 || busy === 1'b1) nvalid++;
      end
      n_total++;
      if (nvalid !== 0) begin
         $display("FAIL abort_no_valid: got %0d active cycles want 0", nvalid);
      end else n_pass++;
      run_job(pk_c(4,4,0,0,0,0), pk_r(2,0,0), 2'b00, lat, cand, ba, bh);
      n_total++;
      if (cand !== CNT_W'(13) || lat !== LAT) begin
         $display("FAIL abort_next_job: got cnt=%0d lat=%0d want 13 %0d",
                  cand, lat, LAT);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_isolation();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/set_region_counter.md
# set_region_counter

Parametrised lattice-set counter: loads up to three circles (A, B, C) on a GRID_N×GRID_N integer grid, scans every grid point once, and reports how many points satisfy the selected set expression. It generalises the two-circle, fixed 8×8 set-counting engine in three ways: grid size and coordinate width are parameters, a third circle is added, and an "exactly two of three" mode is supported. It sits behind the host request interface and returns one count per request.

## Interface
- GRID_N, 8: grid spans coordinates 1..GRID_N on both axes; must satisfy GRID_N ≤ 2^COORD_W − 1.
- COORD_W, 4: width of each coordinate and radius field.
- CNT_W (localparam), $clog2(GRID_N*GRID_N+1): width of the count.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  request strobe; sampled only in IDLE.
- central  in  6*COORD_W  packed centres {xA,yA,xB,yB,xC,yC}, with xA in the MSBs.
- radius  in  3*COORD_W  packed radii {rA,rB,rC}, with rA in the MSBs.
- mode  in  2  set expression, sampled together with en.
- busy  out  1  job in progress; reset value 0.
- valid  out  1  one-cycle result strobe; reset value 0.
- candidate  out  CNT_W  result count; reset value 0; holds its last result until the next one is produced.

## Operation
- Modes, with membership tested per point P:
  - 00: count P in A.
  - 01: count P in A∧B.
  - 10: count P in A⊕B.
  - 11: count P in exactly two of {A,B,C}.
- C is ignored in modes 00–10. B is ignored in mode 00.
- Membership test: (Px−cx)² + (Py−cy)² ≤ r².
  - Use absolute differences (COORD_W bits), squares (2·COORD_W bits), and a sum of 2·COORD_W+1 bits. No truncation anywhere.
- Centres are not clipped. Any portion of a circle outside the grid simply contributes no points. Centre coordinates 0 or >GRID_N are legal.
- r=0 selects only the centre point.
- FSM states:
  - IDLE: en=1 → capture central, radius and mode; clear the counter; set P=(1,1); busy<=1; go to SCAN.
  - SCAN: evaluate P and increment the counter on a hit. Scan order is row-major: x increments first, wrapping to 1 and incrementing y at x=GRID_N. When P=(GRID_N,GRID_N), write candidate<=cnt+hit, set valid<=1, and go to DONE.
  - DONE: valid<=0, busy<=0, go to IDLE.
- Input changes during SCAN or DONE have no effect, because operands are registered at capture. en is ignored outside IDLE.

## Timing
- Let edge E0 be the edge that samples en in IDLE.
- SCAN occupies edges E1..E(GRID_N²). Exactly one point is evaluated per cycle.
- valid is high for exactly one cycle, following edge E(GRID_N²). candidate is stable with the new value from that cycle onward.
- busy is high from after E0 through the valid cycle, and low from E(GRID_N²+1).
- Latency from E0 to valid is GRID_N² cycles (64 at the default). This is fixed regardless of radius and mode.
- An en held high through DONE is not accepted at E(GRID_N²+1). The earliest new accept is E(GRID_N²+2).
- rst asserted at any time, including mid-SCAN:
  - busy, valid, candidate and the counter go to 0 immediately.
  - The FSM returns to IDLE.
  - The aborted job produces no valid.

## Structure
- Shared package set_region_pkg holds:
  - the mode encoding constants: MODE_A, MODE_AND, MODE_XOR, MODE_TWO_OF_THREE;
  - the state enum: IDLE, SCAN, DONE.
- Sub-module set_point_member: a combinational point-in-circle test (point, centre, radius → hit), parametrised by COORD_W. It is instantiated three times, once per circle.
- The top level contains the FSM, the scan counters, the hit counter and the mode combiner.

## Test plan
All scenarios use defaults GRID_N=8, COORD_W=4.
- Single circle: mode 00, A=(4,4) r=2 → candidate=13; valid exactly 64 cycles after E0; busy low the next cycle.
- Intersection: mode 01, A=(3,3) r2, B=(5,3) r2 → candidate=5.
- XOR: mode 10, same A and B as the intersection case → candidate=16. Also: mode 00, A=(1,1) r2 (clipped by the grid edge) → candidate=6.
- Exactly two of three: mode 11, A=(3,3) r2, B=(5,3) r2, C=(8,8) r0 → candidate=5. Also: mode 00, A=(8,8) r0 → candidate=1.
- Input isolation:
  - Change central, radius and mode and pulse en mid-SCAN → result unchanged, no second job starts.
  - en held high continuously → jobs start 66 cycles apart.
- Reset abort: assert rst at scan cycle 30 → candidate=0, busy=0, no valid pulse. A following job with A=(4,4) r2, mode 00 → candidate=13.
